// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty sequencers.
// Contents: breath_state_t phase encoding, profile mode constants, step counter width.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } breath_state_t;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  localparam int unsigned STEP_W = 32;

endpackage

// File: rtl/pwm_tick_gen.sv
// Step prescaler: pulses tick once every step_thresh+1 cycles.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clr          - holds the counter at zero and suppresses tick
//   step_thresh  - period minus one, in clk cycles
//   tick         - combinational strobe, high in the cycle the count reaches threshold
module pwm_tick_gen #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] step_thresh,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic         hit_c;

  // >= rather than == so a threshold lowered below the running count recovers at once
  assign hit_c = (cnt_q >= step_thresh);
  assign tick  = hit_c && !clr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (hit_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/breath_duty_gen.sv
// Breathing duty-word sequencer feeding the PWM core duty input.
// Produces a sawtooth or triangle (with peak/trough dwell) ramp, one step per tick.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   enable       - run/stop; low returns to IDLE with duty 0
//   mode         - 0 sawtooth, 1 triangle; sampled on IDLE exit and at each cycle_done
//   step_thresh  - clk cycles per step minus one
//   hold_steps   - dwell ticks minus one at peak and trough (triangle)
//   duty         - R+1 bit duty word, full scale 2**R
//   duty_valid   - pulse when duty takes a new value
//   phase        - current breath_state_t encoding
//   cycle_done   - pulse at the end of each full profile period
// Build option: define GAMMA_CORR_EN to square-law correct duty (one extra cycle of latency).
module breath_duty_gen
  import pwm_pkg::*;
#(
  parameter int unsigned R      = 8,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [STEP_W-1:0] step_thresh,
  input  logic [HOLD_W-1:0] hold_steps,
  output logic [R:0]        duty,
  output logic              duty_valid,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam int unsigned DW   = R + 1;
  localparam logic [R:0]  FULL = DW'(1) << R;

  breath_state_t     state_q, state_d;
  logic [R:0]        lin_q, lin_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              tick_c;
  logic              clr_c;

  // Prescaler idles at zero outside an active profile
  assign clr_c = (state_q == IDLE) || !enable;

  pwm_tick_gen #(.W(STEP_W)) u_tick (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr_c),
    .step_thresh (step_thresh),
    .tick        (tick_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lin_q   <= '0;
      hold_q  <= '0;
      mode_q  <= MODE_SAW;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and ramp update
  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      lin_d   = '0;
      hold_d  = '0;
      valid_d = (lin_q != '0);
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RISE;
          mode_d  = mode;
          lin_d   = '0;
        end
        RISE: begin
          if (tick_c) begin
            if (lin_q == FULL) begin
              if (mode_q == MODE_SAW) begin
                lin_d   = '0;
                valid_d = 1'b1;
                done_d  = 1'b1;
                mode_d  = mode;
              end else begin
                state_d = HOLD_HI;
                hold_d  = '0;
              end
            end else begin
              lin_d   = lin_q + DW'(1);
              valid_d = 1'b1;
              // Triangle enters the peak dwell on the step that reaches full scale
              if (mode_q == MODE_TRI && lin_q == FULL - DW'(1)) begin
                state_d = HOLD_HI;
                hold_d  = '0;
              end
            end
          end
        end
        HOLD_HI: begin
          if (tick_c) begin
            if (hold_q == hold_steps) begin
              state_d = FALL;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        FALL: begin
          if (tick_c) begin
            if (lin_q != '0) begin
              lin_d   = lin_q - DW'(1);
              valid_d = 1'b1;
            end
            if (lin_q <= DW'(1)) begin
              state_d = HOLD_LO;
              hold_d  = '0;
            end
          end
        end
        HOLD_LO: begin
          if (tick_c) begin
            if (hold_q == hold_steps) begin
              state_d = RISE;
              done_d  = 1'b1;
              mode_d  = mode;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          lin_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign phase      = state_q;
  assign cycle_done = done_q;

`ifdef GAMMA_CORR_EN
  localparam int unsigned SQW = 2 * R + 2;

  logic [SQW-1:0] sq_c;
  logic [R:0]     duty_q;
  logic           duty_valid_q;

  // Square-law stage; full-scale input maps back to full scale
  assign sq_c = SQW'(lin_q) * SQW'(lin_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_q       <= DW'(sq_c >> R);
      duty_valid_q <= valid_q;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
`else
  assign duty       = lin_q;
  assign duty_valid = valid_q;
`endif

endmodule

// File: doc/breath_duty_gen.md
Name: breath_duty_gen

Overview:
Upstream duty-cycle sequencer for the enhanced PWM core. Generates a time-varying duty word (sawtooth or triangle "breathing" profile with peak/trough holds) on a programmable step period. Output feeds the PWM core's duty input directly (R+1 bits, full scale = 2**R = 100%).

Parameters:
R, 8, PWM resolution; duty spans 0..2**R inclusive
HOLD_W, 8, width of hold_steps input

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run/stop; low forces IDLE
mode  input  1  0 = sawtooth, 1 = triangle with holds
step_thresh  input  32  tick period minus one (clk cycles per duty step = step_thresh+1)
hold_steps  input  HOLD_W  ticks to dwell at peak and at trough (triangle only)
duty  output  R+1  duty word to PWM core
duty_valid  output  1  one-cycle pulse when duty changes
phase  output  3  current state encoding
cycle_done  output  1  one-cycle pulse at end of each full profile period

Behaviour:
- Reset: sync on posedge clk; duty=0, duty_valid=0, cycle_done=0, phase=IDLE, tick counter=0, hold counter=0, latched mode=0.
- Tick generator: counter increments each cycle; when counter >= step_thresh, tick=1 for one cycle and counter<=0. Using >= guarantees recovery if step_thresh is lowered mid-count. step_thresh=0 -> tick every cycle.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE: duty=0, counter held at 0. On enable=1: latch mode, go RISE next cycle. Tick counter starts then.
- enable=0 in any state: next cycle IDLE, duty=0, counter=0; duty_valid pulses if duty was nonzero.
- RISE, on tick: if duty < 2**R, duty+1. If duty == 2**R: sawtooth -> duty<=0, cycle_done=1, stay RISE. Triangle -> go HOLD_HI, hold counter=0.
- HOLD_HI, on tick: hold counter+1; when hold counter == hold_steps, go FALL. hold_steps=0 -> leave on first tick.
- FALL, on tick: duty-1; when duty reaches 0, go HOLD_LO, hold counter=0.
- HOLD_LO: same dwell rule, then RISE, cycle_done=1 on that transition.
- mode is sampled only on IDLE exit and on every cycle_done. Mid-profile mode changes take effect at the next boundary.
- duty_valid: registered, asserted the cycle duty takes a new value. Never asserted during holds.
- duty never exceeds 2**R and never underflows below 0.
- Latency: duty updates on the clk edge following the tick, 1 cycle.
- Triangle period = (2*2**R + 2*(hold_steps+1)) ticks.

Optional Feature:
GAMMA_CORR_EN
- Defined: output duty = (lin*lin) >> R, where lin is the internal linear ramp. Computed in a registered stage, so duty and duty_valid gain one extra cycle of latency and stay aligned. Values: lin=2**R -> 2**R; lin=2**(R-1) -> 2**(R-2).
- Undefined: duty = lin directly, latency as above.
- State, tick and cycle_done timing are unchanged in both builds.

Decomposition:
- Package pwm_pkg:
  - typedef enum logic [2:0] breath_state_t {IDLE, RISE, HOLD_HI, FALL, HOLD_LO}
  - constants MODE_SAW=1'b0, MODE_TRI=1'b1
- Sub-module pwm_tick_gen: prescaler with ports clk, reset, clr, step_thresh, tick. Reusable by other sequencers.

Test Plan:
- R=3, step_thresh=0, mode=0, enable=1 -> duty 0,1,..,8, then 0, one step per cycle. cycle_done pulses on the 8->0 transition. duty_valid high every step.
- R=3, step_thresh=3, mode=1, hold_steps=2 -> duty changes every 4 cycles, 0..8. Holds at 8 for 3 ticks (12 cycles), falls to 0, holds 3 ticks. cycle_done after 22 ticks (88 cycles).
- Mid-RISE at duty=5, drop enable for 1 cycle -> next cycle duty=0, phase=IDLE, one duty_valid. Re-enable restarts from 0.
- Toggle mode 0->1 while duty=3 in sawtooth -> profile remains sawtooth until cycle_done, then triangle.
- Assert reset while in FALL with duty=6 -> next edge duty=0, phase=IDLE, outputs low. step_thresh lowered 100->2 while counter=50 -> tick next cycle.
- GAMMA_CORR_EN build, R=8, linear ramp -> duty 0 at lin=0, 64 at lin=128, 256 at lin=256, each one cycle later than the linear build.
